// File: rtl/asc_fifo_sync.sv
// asc_fifo_sync: single-clock circular-buffer FIFO with show-ahead output.
// Keeps the asc_fifo port names and parameters for drop-in replacement.
// Optional build macro ASC_FIFO_STATUS_EN adds o_count, o_almost_full and
// o_almost_empty, all decoded from the registered pointers.
`timescale 1ns/1ps

module asc_fifo_sync #(
    parameter int P_DEPTH  = 8,
    parameter int P_DATA_W = 8,
    parameter int P_AF_LVL = P_DEPTH - 2,
    parameter int P_AE_LVL = 2
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        w_en,
    input  logic [P_DATA_W-1:0]         i_data,
    output logic                        o_full,
    input  logic                        r_en,
    output logic                        o_empty,
    output logic [P_DATA_W-1:0]         o_data
`ifdef ASC_FIFO_STATUS_EN
    ,
    output logic [$clog2(P_DEPTH):0]    o_count,
    output logic                        o_almost_full,
    output logic                        o_almost_empty
`endif
);

    localparam int AW = $clog2(P_DEPTH);
    localparam int PW = AW + 1;

    // Elaboration-time sanity checks on the configuration.
    if (P_DEPTH < 2 || (P_DEPTH & (P_DEPTH - 1)) != 0) begin : g_chk_depth
        $error("asc_fifo_sync: P_DEPTH must be a power of two >= 2");
    end
    if (P_AF_LVL < 0 || P_AF_LVL > P_DEPTH || P_AE_LVL < 0 || P_AE_LVL > P_DEPTH) begin : g_chk_lvl
        $error("asc_fifo_sync: almost-full/empty levels must lie in 0..P_DEPTH");
    end

    logic [P_DATA_W-1:0] mem_q [P_DEPTH];
    logic [PW-1:0]       wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]       rd_ptr_q, rd_ptr_d;
    logic                push, pop;

    // Flags decode the registered pointers; the MSB is the lap (wrap) bit.
    always_comb begin
        o_empty = (wr_ptr_q == rd_ptr_q);
        o_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                  (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    end

    // Accept gates use the pre-edge flags, so a push into a full FIFO is
    // dropped even when a pop happens on the same edge.
    always_comb begin
        push     = w_en && !o_full;
        pop      = r_en && !o_empty;
        wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
        rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    end

    // Pointer registers with asynchronous reset to the empty state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage array, deliberately not reset; only written entries are read.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q[AW-1:0]] <= i_data;
        end
    end

    // Show-ahead head word, forced to zero while nothing is stored.
    always_comb begin
        o_data = '0;
        if (!o_empty) begin
            o_data = mem_q[rd_ptr_q[AW-1:0]];
        end
    end

`ifdef ASC_FIFO_STATUS_EN
    localparam logic [PW-1:0] AF_LVL_C = PW'(P_AF_LVL);
    localparam logic [PW-1:0] AE_LVL_C = PW'(P_AE_LVL);

    // Occupancy and threshold flags; modular subtraction handles wrap.
    always_comb begin
        o_count        = wr_ptr_q - rd_ptr_q;
        o_almost_full  = (o_count >= AF_LVL_C);
        o_almost_empty = (o_count <= AE_LVL_C);
    end
`endif

endmodule

// File: tb/tb_asc_fifo_sync.sv
// Testbench for asc_fifo_sync: directed vectors with a queue scoreboard.
// Stimulus pushes each word it expects the FIFO to accept; a monitor pops
// and compares whenever the DUT pops its show-ahead head word.
`timescale 1ns/1ps

module tb_asc_fifo_sync;

    localparam int DEPTH = 8;
    localparam int DW    = 8;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          w_en = 1'b0;
    logic [DW-1:0] i_data = '0;
    logic          r_en = 1'b0;
    logic          o_full;
    logic          o_empty;
    logic [DW-1:0] o_data;
`ifdef ASC_FIFO_STATUS_EN
    logic [3:0]    o_count;
    logic          o_almost_full;
    logic          o_almost_empty;
`endif

    int vectors = 0;
    int errors  = 0;
    int cnt     = 0;          // bench model occupancy
    logic [DW-1:0] q_exp[$];  // expected read-out order

    asc_fifo_sync #(.P_DEPTH(DEPTH), .P_DATA_W(DW)) dut (
        .clk            (clk),
        .rst            (rst),
        .w_en           (w_en),
        .i_data         (i_data),
        .o_full         (o_full),
        .r_en           (r_en),
        .o_empty        (o_empty),
        .o_data         (o_data)
`ifdef ASC_FIFO_STATUS_EN
        ,
        .o_count        (o_count),
        .o_almost_full  (o_almost_full),
        .o_almost_empty (o_almost_empty)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        vectors++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    // One clock of stimulus; the model decides what the FIFO must accept.
    task automatic step(input logic w, input logic [DW-1:0] d, input logic r);
        bit push_ok, pop_ok;
        w_en   = w;
        i_data = d;
        r_en   = r;
        push_ok = w && (cnt < DEPTH);
        pop_ok  = r && (cnt > 0);
        if (push_ok) q_exp.push_back(d);
        cnt = cnt + int'(push_ok) - int'(pop_ok);
        @(posedge clk);
        #1;
        w_en = 1'b0;
        r_en = 1'b0;
    endtask

    // Monitor: every pop the DUT performs must match the scoreboard head.
    always @(negedge clk) begin
        if (!rst && r_en && !o_empty) begin
            if (q_exp.size() == 0) begin
                vectors++;
                errors++;
                $display("FAIL pop_unexpected: got %0h expected no data", o_data);
            end else begin
                logic [DW-1:0] e;
                e = q_exp.pop_front();
                chk("pop_data", 32'(o_data), 32'(e));
            end
        end
    end

    // Watchdog so the run always ends.
    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        // Reset then idle.
        #2;
        chk("rst_empty", 32'(o_empty), 1);
        chk("rst_full",  32'(o_full),  0);
        chk("rst_data",  32'(o_data),  0);
        @(posedge clk); @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        chk("idle_empty", 32'(o_empty), 1);
        chk("idle_full",  32'(o_full),  0);
        chk("idle_data",  32'(o_data),  0);

        // Fill with 0..7.
        for (int i = 0; i < 8; i++) begin
            step(1'b1, DW'(i), 1'b0);
            chk("fill_empty", 32'(o_empty), 0);
            chk("fill_full",  32'(o_full),  (i == 7) ? 1 : 0);
`ifdef ASC_FIFO_STATUS_EN
            chk("fill_count", 32'(o_count), 32'(i + 1));
            chk("fill_af",    32'(o_almost_full),  (i + 1 >= 6) ? 1 : 0);
            chk("fill_ae",    32'(o_almost_empty), (i + 1 <= 2) ? 1 : 0);
`endif
        end
        chk("head_after_fill", 32'(o_data), 0);

        // Write to full FIFO is dropped.
        step(1'b1, 8'hAA, 1'b0);
        chk("wfull_full", 32'(o_full), 1);
        chk("wfull_head", 32'(o_data), 0);

        // Drain: 0..7 expected by the monitor.
        for (int i = 0; i < 8; i++) begin
            step(1'b0, 8'h00, 1'b1);
            chk("drain_empty", 32'(o_empty), (i == 7) ? 1 : 0);
            chk("drain_full",  32'(o_full),  0);
        end
        chk("drain_data0", 32'(o_data), 0);

        // Reads of an empty FIFO are ignored; a later write reads back.
        for (int i = 0; i < 3; i++) step(1'b0, 8'h00, 1'b1);
        chk("rempty_empty", 32'(o_empty), 1);
        step(1'b1, 8'h55, 1'b0);
        chk("w55_empty", 32'(o_empty), 0);
        chk("w55_head",  32'(o_data), 32'h55);
        step(1'b0, 8'h00, 1'b1);
        chk("r55_empty", 32'(o_empty), 1);

        // Hold 4 entries, then 20 simultaneous push/pop cycles across wrap.
        for (int i = 0; i < 4; i++) step(1'b1, DW'(8'h10 + i), 1'b0);
        for (int k = 0; k < 20; k++) begin
            step(1'b1, DW'(8'h14 + k), 1'b1);
            chk("steady_empty", 32'(o_empty), 0);
            chk("steady_full",  32'(o_full),  0);
`ifdef ASC_FIFO_STATUS_EN
            chk("steady_count", 32'(o_count), 4);
`endif
        end
        chk("steady_head", 32'(o_data), 32'h24);
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 1'b1);
        chk("steady_drained", 32'(o_empty), 1);

        // Full FIFO with push and pop together: pop only.
        for (int i = 0; i < 8; i++) step(1'b1, DW'(8'h80 + i), 1'b0);
        chk("pf_full", 32'(o_full), 1);
        step(1'b1, 8'hEE, 1'b1);
        chk("pf_full_after",  32'(o_full),  0);
        chk("pf_empty_after", 32'(o_empty), 0);
        chk("pf_head",        32'(o_data),  32'h81);
        for (int i = 0; i < 7; i++) step(1'b0, 8'h00, 1'b1);
        chk("pf_drained", 32'(o_empty), 1);

        // Asynchronous reset pulse mid-burst.
        for (int i = 0; i < 3; i++) step(1'b1, DW'(8'h30 + i), 1'b0);
        chk("pre_rst_empty", 32'(o_empty), 0);
        #2;
        rst = 1'b1;
        #0.5;
        chk("arst_empty", 32'(o_empty), 1);
        chk("arst_full",  32'(o_full),  0);
        chk("arst_data",  32'(o_data),  0);
        #0.5;
        rst = 1'b0;
        q_exp.delete();
        cnt = 0;
        @(posedge clk); #1;
        chk("post_rst_empty", 32'(o_empty), 1);
        step(1'b1, 8'h66, 1'b0);
        chk("post_rst_head", 32'(o_data), 32'h66);
        step(1'b0, 8'h00, 1'b1);
        chk("post_rst_drained", 32'(o_empty), 1);

        chk("scoreboard_left", 32'(q_exp.size()), 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end

endmodule
